axi_rd: RTL and testbench
=========================

// Module: axi_rd
// PURPOSE
//   AXI3 read master for cache refills and uncached loads. Sits beside axi_wr in
//   the sram_to_axi bridge and serves two requesters: the I-cache and the D-cache.
//   Keeps one transaction outstanding and assembles the R beats into a line buffer.
//   Returns the whole line to the requester in a single-cycle pulse.
// PARAMETERS
//   BYTES_PER_LINE   16                 cache line size in bytes (power of 2, >=4)
//   WORDS_PER_LINE   BYTES_PER_LINE/4   beats per burst refill
//   PTR_WIDTH        clog2(WORDS)       beat pointer width (min 1)
//   LINE_WIDTH       WORDS*32           returned line width
//   ARID_I / ARID_D  0 / 1              arid driven for I / D transactions
// PORTS
//   clk            in   1    clock; all state updates on posedge
//   reset          in   1    synchronous, active-high
//   i_rd_req       in   1    I-cache line refill request; held until i_rd_rdy
//   i_rd_addr      in   32   I-cache refill address
//   i_rd_rdy       out  1    request accepted this cycle
//   i_ret_valid    out  1    one-cycle pulse: i_ret_data valid
//   i_ret_data     out  LW   refilled line, word 0 in bits [31:0]
//   d_rd_req       in   1    D-cache read request; held until d_rd_rdy
//   d_rd_burst     in   1    1 = line refill, 0 = single uncached beat
//   d_rd_size      in   2    byte size code for uncached beat
//   d_rd_addr      in   32   D-cache read address
//   d_rd_rdy       out  1    request accepted this cycle
//   d_ret_valid    out  1    one-cycle pulse: d_ret_data valid
//   d_ret_data     out  LW   returned line/word, word 0 in bits [31:0]
//   wr_idle        in   1    from axi_wr: write buffer drained, no write in flight
//   read_unfinish  out  1    to axi_wr: a read transaction is in progress
//   arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  4/32/8/3/2/2/4/3
//   arvalid out 1, arready in 1        AXI AR channel
//   rid in 4, rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1
// BEHAVIOUR
//   Reset: state IDLE; arvalid, rready, i/d_ret_valid, read_unfinish = 0; ptr = 0.
//   States: IDLE -> AR -> R -> RET -> IDLE.
//   IDLE: the D request wins when d_rd_req & wr_idle, else the I request wins when i_rd_req.
//     The winner's rdy is combinational in IDLE. The block latches addr, burst, size, owner
//     and clears buf and ptr. It goes to AR the next cycle.
//     A D request with wr_idle=0 is not accepted, which preserves read-after-write
//     ordering; an I request may be granted instead.
//     I requests always burst.
//   AR: arvalid=1, address fields held stable; on arready go to R. No timeout.
//     Burst: araddr = addr with low clog2(BYTES) bits zeroed, arlen=WORDS-1,
//       arsize=3'b010, arburst=INCR(01).
//     Single: araddr = addr unmodified, arlen=0, arsize={1'b0,size}, arburst=INCR.
//     arlock/arcache/arprot = 0; arid = ARID of owner.
//   R: rready=1. Each rvalid&rready writes rdata to buf word[ptr]; ptr increments mod WORDS.
//     A beat with rlast=1 ends the transaction: go to RET regardless of ptr.
//     On a short burst, unwritten words stay 0. On a long burst, ptr wraps and overwrites.
//     rresp and rid are ignored (single outstanding).
//   RET: owner's ret_valid=1 for exactly one cycle, ret_data=buf; go to IDLE.
//     The other requester's ret_valid stays 0. ret_data is held until the next accept.
//   read_unfinish = state != IDLE.
//   Latency (arready, rvalid always 1): accept c0, arvalid c1, beats c2..c(1+WORDS),
//     ret_valid c(2+WORDS). Back-to-back requests lose one IDLE cycle.
//   Reset mid-transaction: return to IDLE at once with no ret pulse; the interconnect is
//     reset with the core.
// TESTING
//   1 I refill 0xBFC0_0014, arready/rvalid=1, beats 0x11,0x22,0x33,0x44 -> araddr
//     0xBFC0_0010, arlen 3, arsize 2. i_ret_valid once at c6, data {0x44,0x33,0x22,0x11}.
//   2 I and D requests in the same cycle, wr_idle=1 -> d_rd_rdy=1, i_rd_rdy=0, arid=1.
//     The I request is served after d_ret_valid, with arid=0.
//   3 D uncached, addr 0x1FAF_0002, size 1, wr_idle=0 for 3 cycles then 1 -> no accept
//     while wr_idle=0. Then arlen 0, arsize 1, araddr 0x1FAF_0002, d_ret_data[31:0]=rdata,
//     upper words 0.
//   4 arready low 5 cycles, rvalid toggling every other cycle -> araddr stable, arvalid held.
//     Only handshaked beats are stored, in order. read_unfinish=1 until RET.
//   5 rlast on beat 2 of 4 -> RET after beat 2, words 2..3 = 0, ret_valid single pulse.
//   6 reset asserted in R after 2 beats -> next cycle arvalid=rready=ret_valid=0, state IDLE.
//     A new request is then served correctly.

Source files
------------

// File: rtl/axi_rd.sv
// AXI3 read master shared by the I-cache and D-cache: one outstanding read,
// R beats assembled into a line buffer, whole line returned in a one-cycle pulse.
module axi_rd #(
  parameter int unsigned BYTES_PER_LINE = 16,
  parameter logic [3:0]  ARID_I         = 4'd0,
  parameter logic [3:0]  ARID_D         = 4'd1,
  localparam int unsigned WORDS_PER_LINE = BYTES_PER_LINE / 4,
  localparam int unsigned PTR_WIDTH      = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1,
  localparam int unsigned LINE_WIDTH     = WORDS_PER_LINE * 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-cache requester
  input  logic                  i_rd_req,
  input  logic [31:0]           i_rd_addr,
  output logic                  i_rd_rdy,
  output logic                  i_ret_valid,
  output logic [LINE_WIDTH-1:0] i_ret_data,
  // D-cache requester
  input  logic                  d_rd_req,
  input  logic                  d_rd_burst,
  input  logic [1:0]            d_rd_size,
  input  logic [31:0]           d_rd_addr,
  output logic                  d_rd_rdy,
  output logic                  d_ret_valid,
  output logic [LINE_WIDTH-1:0] d_ret_data,
  // Coordination with the write master
  input  logic                  wr_idle,
  output logic                  read_unfinish,
  // AXI AR channel
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  // AXI R channel
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StRet} state_e;

  localparam logic [31:0]          LineMask = ~(32'(BYTES_PER_LINE) - 32'd1);
  localparam logic [PTR_WIDTH-1:0] PtrMax   = PTR_WIDTH'(WORDS_PER_LINE - 1);

  state_e                         state_q, state_d;
  logic [31:0]                    addr_q;
  logic                           burst_q;
  logic [1:0]                     size_q;
  logic                           owner_q;  // 1 = D-cache, 0 = I-cache
  logic [WORDS_PER_LINE-1:0][31:0] buf_q;
  logic [PTR_WIDTH-1:0]           ptr_q;
  logic                           d_grant, i_grant;

  // Single outstanding read, so rid and rresp carry no information we act on.
  logic unused_r;
  assign unused_r = ^{rid, rresp};

  // Arbitration, next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    d_grant     = d_rd_req & wr_idle;  // hold D reads behind pending writes
    i_grant     = i_rd_req & ~d_grant;
    d_rd_rdy    = 1'b0;
    i_rd_rdy    = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    i_ret_valid = 1'b0;
    d_ret_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        d_rd_rdy = d_grant;
        i_rd_rdy = i_grant;
        if (d_grant || i_grant) state_d = StAr;
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) state_d = StR;
      end
      StR: begin
        rready = 1'b1;
        if (rvalid && rlast) state_d = StRet;
      end
      StRet: begin
        i_ret_valid = ~owner_q;
        d_ret_valid = owner_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // AR fields derive from the latched request and stay stable through AR.
  assign arid          = owner_q ? ARID_D : ARID_I;
  assign araddr        = burst_q ? (addr_q & LineMask) : addr_q;
  assign arlen         = burst_q ? 8'(WORDS_PER_LINE - 1) : 8'd0;
  assign arsize        = burst_q ? 3'b010 : {1'b0, size_q};
  assign arburst       = 2'b01;
  assign arlock        = 2'b00;
  assign arcache       = 4'b0000;
  assign arprot        = 3'b000;
  assign read_unfinish = (state_q != StIdle);
  assign i_ret_data    = buf_q;
  assign d_ret_data    = buf_q;

  // State, request latch and line buffer fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      burst_q <= 1'b0;
      size_q  <= '0;
      owner_q <= 1'b0;
      buf_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && (d_grant || i_grant)) begin
        addr_q  <= d_grant ? d_rd_addr : i_rd_addr;
        burst_q <= d_grant ? d_rd_burst : 1'b1;
        size_q  <= d_grant ? d_rd_size : 2'b10;
        owner_q <= d_grant;
        buf_q   <= '0;
        ptr_q   <= '0;
      end
      // Beats past the line wrap around and overwrite earlier words.
      if (state_q == StR && rvalid) begin
        buf_q[ptr_q] <= rdata;
        ptr_q        <= (ptr_q == PtrMax) ? '0 : ptr_q + PTR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_rd.sv
// Randomized scoreboard bench for axi_rd with a behavioural AXI slave.
module tb_axi_rd;

  localparam int W  = 4;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_rd_req, d_rd_req, d_rd_burst, wr_idle;
  logic [31:0]   i_rd_addr, d_rd_addr;
  logic [1:0]    d_rd_size;
  logic          i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, read_unfinish;
  logic [LW-1:0] i_ret_data, d_ret_data;
  logic [3:0]    arid, rid;
  logic [31:0]   araddr, rdata;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, arlock, rresp;
  logic [3:0]    arcache;
  logic          arvalid, arready, rlast, rvalid, rready;

  axi_rd dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_burst(d_rd_burst), .d_rd_size(d_rd_size),
    .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
    .wr_idle(wr_idle), .read_unfinish(read_unfinish),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  ar_t           exp_ar[$];
  bit            own_q[$];    // 1 = D owner
  logic [LW-1:0] line_q[$];
  logic [31:0]   data_q[$];   // forced beat data, random when empty

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ret_count = 0;
  int acc_cyc, ret_cyc;
  bit busy = 0;
  logic [LW-1:0] last_ret_data;

  // slave configuration
  bit cfg_rand = 0;
  bit cfg_r_toggle = 0;
  int cfg_ar_wait = 0;
  int cfg_last_beat = -1;
  // slave state
  bit in_r = 0;
  int beat_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Behavioural AXI slave: drives just after posedge, confirms handshakes at the next edge.
  initial begin : slave
    logic [31:0]   words[W];
    logic [7:0]    cur_len;
    logic [LW-1:0] line;
    int            ar_wait;
    bit            r_tog, stall, send;
    int            last_idx;
    arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0; rresp = 0;
    ar_wait = 0; r_tog = 0; cur_len = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        in_r = 0; arready = 0; rvalid = 0; rlast = 0; ar_wait = 0; beat_n = 0;
      end else begin
        if (arready) begin
          arready = 0; in_r = 1; beat_n = 0;
          for (int k = 0; k < W; k++) words[k] = 32'h0;
        end else if (rvalid) begin
          words[beat_n % W] = rdata;
          beat_n++;
          if (rlast) begin
            for (int k = 0; k < W; k++) line[k*32 +: 32] = words[k];
            line_q.push_back(line);
            in_r = 0;
          end
          rvalid = 0; rlast = 0;
        end
        if (!in_r && arvalid) begin
          stall = cfg_rand ? ($urandom_range(0, 2) == 0) : (ar_wait < cfg_ar_wait);
          if (stall) ar_wait++;
          else begin
            arready = 1; cur_len = arlen; ar_wait = 0;
          end
        end
        rdata = $urandom;
        rid = 4'($urandom);
        rresp = 2'($urandom);
        if (in_r && rready) begin
          r_tog = !r_tog;
          send = cfg_rand ? ($urandom_range(0, 2) != 0) : (!cfg_r_toggle || r_tog);
          if (send) begin
            rvalid = 1;
            if (data_q.size() > 0) rdata = data_q.pop_front();
            last_idx = (cfg_last_beat >= 0) ? cfg_last_beat : int'(cur_len);
            rlast = (beat_n == last_idx);
          end
        end
      end
    end
  end

  // Monitor and reference model: arbitration, AR fields, return pulses, busy flag.
  always @(negedge clk) begin : monitor
    ar_t  e;
    bit   busy0, ed, ei, bst, o;
    logic [31:0] a;
    logic [LW-1:0] l;
    if (reset) begin
      busy = 0;
      exp_ar.delete(); own_q.delete(); line_q.delete();
    end else begin
      busy0 = busy;
      check("read_unfinish", LW'(read_unfinish), LW'(busy0));
      if (i_ret_valid || d_ret_valid) begin
        if (own_q.size() == 0 || line_q.size() == 0) fail_now("ret_unexpected");
        else begin
          o = own_q.pop_front();
          l = line_q.pop_front();
          check("ret_owner", LW'({i_ret_valid, d_ret_valid}), LW'(o ? 2'b01 : 2'b10));
          check("ret_data", o ? d_ret_data : i_ret_data, l);
        end
        last_ret_data = d_ret_valid ? d_ret_data : i_ret_data;
        ret_count++;
        ret_cyc = cyc;
        busy = 0;
      end
      if (d_rd_req || i_rd_req) begin
        ed = !busy0 && d_rd_req && wr_idle;
        ei = !busy0 && i_rd_req && !ed;
        check("d_rd_rdy", LW'(d_rd_rdy), LW'(ed));
        check("i_rd_rdy", LW'(i_rd_rdy), LW'(ei));
        if (ed || ei) begin
          bst = ed ? d_rd_burst : 1'b1;
          a = ed ? d_rd_addr : i_rd_addr;
          e.id = ed ? 4'd1 : 4'd0;
          e.addr = bst ? {a[31:4], 4'h0} : a;
          e.len = bst ? 8'(W - 1) : 8'd0;
          e.size = bst ? 3'd2 : {1'b0, d_rd_size};
          exp_ar.push_back(e);
          own_q.push_back(ed);
          acc_cyc = cyc;
          busy = 1;
        end
      end
      if (arvalid) begin
        if (exp_ar.size() == 0) fail_now("ar_unexpected");
        else begin
          e = exp_ar[0];
          check("ar_fields",
                LW'({arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot}),
                LW'({e.id, e.addr, e.len, e.size, 2'b01, 2'b00, 4'h0, 3'h0}));
          if (arready) void'(exp_ar.pop_front());
        end
      end
    end
  end

  task automatic wait_ret(input int start);
    int n;
    n = 0;
    while (ret_count == start && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (ret_count == start) fail_now("ret_timeout");
  endtask

  task automatic req(input bit is_d, input bit burst, input logic [1:0] size,
                     input logic [31:0] addr, input int idle_lo);
    int start;
    bit got;
    start = ret_count;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #2;
      wr_idle = (k >= idle_lo);
      if (is_d) begin
        d_rd_req = 1; d_rd_burst = burst; d_rd_size = size; d_rd_addr = addr;
      end else begin
        i_rd_req = 1; i_rd_addr = addr;
      end
      @(negedge clk);
      got = is_d ? d_rd_rdy : i_rd_rdy;
    end
    @(posedge clk); #2;
    d_rd_req = 0; i_rd_req = 0; wr_idle = 1;
    d_rd_addr = $urandom; i_rd_addr = $urandom;
    if (!got) fail_now("accept_timeout");
    else wait_ret(start);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int start, n;
    bit got;
    reset = 1; i_rd_req = 0; d_rd_req = 0; d_rd_burst = 0; d_rd_size = 0;
    i_rd_addr = 0; d_rd_addr = 0; wr_idle = 1;
    repeat (3) @(posedge clk);
    #3 reset = 0;
    @(negedge clk);
    check("rst_arvalid", LW'(arvalid), '0);
    check("rst_rready", LW'(rready), '0);
    check("rst_ret_valid", LW'({i_ret_valid, d_ret_valid}), '0);
    check("rst_unfinish", LW'(read_unfinish), '0);

    // 1: I refill, fixed beats, latency 2+W
    data_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    req(0, 1, 2'd2, 32'hBFC0_0014, 0);
    check("t1_latency", LW'(ret_cyc - acc_cyc), LW'(2 + W));
    check("t1_data", last_ret_data, {32'h44, 32'h33, 32'h22, 32'h11});

    // 2: simultaneous requests, D wins, I follows after D returns
    start = ret_count;
    @(posedge clk); #2;
    wr_idle = 1; i_rd_req = 1; i_rd_addr = 32'h0000_1008;
    d_rd_req = 1; d_rd_burst = 1; d_rd_size = 2; d_rd_addr = 32'h8000_0024;
    @(negedge clk);
    check("t2_d_rdy", LW'(d_rd_rdy), LW'(1));
    check("t2_i_rdy", LW'(i_rd_rdy), LW'(0));
    @(posedge clk); #2 d_rd_req = 0;
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = i_rd_rdy;
    end
    if (!got) fail_now("t2_i_accept");
    check("t2_i_after_d", LW'(ret_count - start), LW'(1));
    @(posedge clk); #2 i_rd_req = 0;
    wait_ret(start + 1);

    // 3: D uncached, blocked by wr_idle for 3 cycles
    req(1, 0, 2'd1, 32'h1FAF_0002, 3);
    check("t3_upper_zero", LW'(last_ret_data[LW-1:32]), '0);

    // 4: AR stalls and gappy R
    cfg_ar_wait = 5; cfg_r_toggle = 1;
    req(0, 1, 2'd2, 32'h0040_0104, 0);
    cfg_ar_wait = 0; cfg_r_toggle = 0;

    // 5: early rlast, then a long burst that wraps
    cfg_last_beat = 1;
    req(1, 1, 2'd2, 32'h2000_0030, 0);
    check("t5_tail_zero", LW'(last_ret_data[LW-1:64]), '0);
    cfg_last_beat = 5;
    req(0, 1, 2'd2, 32'h3000_0040, 0);
    cfg_last_beat = -1;

    // 6: reset during R after two beats
    start = ret_count;
    @(posedge clk); #2 i_rd_req = 1; i_rd_addr = 32'h0BAD_0010;
    @(negedge clk);
    @(posedge clk); #2 i_rd_req = 0;
    n = 0;
    do begin
      @(posedge clk); #3;
      n++;
    end while (!(in_r && beat_n >= 2) && n < 100);
    if (n >= 100) fail_now("t6_beats");
    reset = 1;
    @(posedge clk); #3 reset = 0;
    @(negedge clk);
    check("t6_arvalid", LW'(arvalid), '0);
    check("t6_rready", LW'(rready), '0);
    check("t6_ret_valid", LW'({i_ret_valid, d_ret_valid}), '0);
    check("t6_unfinish", LW'(read_unfinish), '0);
    check("t6_no_ret", LW'(ret_count - start), '0);
    req(1, 1, 2'd2, 32'h4000_0058, 0);

    // random traffic against the slave model
    cfg_rand = 1;
    for (int t = 0; t < 40; t++) begin
      bit is_d;
      is_d = 1'($urandom);
      cfg_last_beat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      req(is_d, is_d ? 1'($urandom) : 1'b1, 2'($urandom_range(0, 2)), $urandom,
          is_d ? $urandom_range(0, 2) : 0);
    end
    cfg_rand = 0; cfg_last_beat = -1;

    repeat (3) @(posedge clk);
    check("end_ar_queue", LW'(exp_ar.size()), '0);
    check("end_own_queue", LW'(own_q.size()), '0);
    check("end_line_queue", LW'(line_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
